hub75_scan_ctrl: RTL

- Scan/refresh controller directly downstream of the dual-half bit-plane frame memory.
- Generates that memory's read address and bit-plane select, and consumes its six RGB bits (rows n and n+32).
- Shifts the bits out to a HUB75 chain and drives panel clock, latch, output-enable and row address.
- Brightness uses binary-code modulation over bit planes 2..7.

---
 rtl/hub75_scan_ctrl_if.sv | 33 +++
 rtl/hub75_scan_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl_if.sv
// Bus bundle for the HUB75 scan controller: frame-memory read port on one
// side, panel drive signals on the other. The controller takes the master
// modport; the frame memory / panel model takes the slave modport.
interface hub75_scan_ctrl_if #(
    parameter int unsigned COL_BITS = 9
);
    // frame memory read side
    logic [COL_BITS+4:0] rd_addr;
    logic [2:0]          rd_bit_plane;
    logic                r0, g0, b0, r1, g1, b1;

    // panel side
    logic                hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic                hub_clk;
    logic                hub_lat;
    logic                hub_oe_n;
    logic [4:0]          hub_row;
    logic                frame_start;

    modport master (
        output rd_addr, rd_bit_plane,
        input  r0, g0, b0, r1, g1, b1,
        output hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
        output hub_clk, hub_lat, hub_oe_n, hub_row, frame_start
    );

    modport slave (
        input  rd_addr, rd_bit_plane,
        output r0, g0, b0, r1, g1, b1,
        input  hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
        input  hub_clk, hub_lat, hub_oe_n, hub_row, frame_start
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan/refresh controller. Reads one line of one bit plane from the
// dual-half frame memory, shifts it into the panel chain at clk/2, latches it
// and shows it for a binary-weighted time while the next line is shifted.
// Planes 2..7 are cycled per row; rows 0..31 are cycled per frame.
module hub75_scan_ctrl #(
    parameter int unsigned COL_BITS  = 9,
    parameter int unsigned BCM_BASE  = 16,
    parameter int unsigned BCM_CNT_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    hub75_scan_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, PRIME, BLANK, LATCH, RUN} state_t;
    // CAP: next edge captures a column and drops hub_clk
    // HIGH: next edge raises hub_clk
    // END: next edge drops hub_clk after the last column
    typedef enum logic [1:0] {SH_CAP, SH_HIGH, SH_END} shift_ph_t;

    localparam logic [COL_BITS-1:0]  LAST_COL = '1;
    localparam logic [BCM_CNT_W-1:0] BASE     = BCM_CNT_W'(BCM_BASE);

    state_t                 state;
    shift_ph_t              sh_ph;
    logic                   sh_busy;
    logic [COL_BITS-1:0]    sh_col;
    logic [4:0]             shift_row;
    logic [2:0]             shift_plane;
    logic [BCM_CNT_W-1:0]   timer;

    logic [COL_BITS+4:0]    addr_q;
    logic [2:0]             plane_q;
    logic [5:0]             data_q;
    logic                   hclk_q;
    logic                   lat_q;
    logic                   oe_n_q;
    logic [4:0]             row_q;
    logic                   fs_q;

    logic [4:0]             nxt_row;
    logic [2:0]             nxt_plane;
    logic                   sh_last;
    logic                   sh_free;

    assign bus.rd_addr      = addr_q;
    assign bus.rd_bit_plane = plane_q;
    assign {bus.hub_r0, bus.hub_g0, bus.hub_b0,
            bus.hub_r1, bus.hub_g1, bus.hub_b1} = data_q;
    assign bus.hub_clk      = hclk_q;
    assign bus.hub_lat      = lat_q;
    assign bus.hub_oe_n     = oe_n_q;
    assign bus.hub_row      = row_q;
    assign bus.frame_start  = fs_q;

    // Next row/plane pointer and shift-engine completion flags.
    always_comb begin
        nxt_row   = shift_row;
        nxt_plane = shift_plane + 3'd1;
        if (shift_plane == 3'd7) begin
            nxt_plane = 3'd2;
            nxt_row   = shift_row + 5'd1;
        end
        sh_last = sh_busy && (sh_ph == SH_END);
        sh_free = !sh_busy || sh_last;
    end

    // Scan FSM, shift engine and display timer with registered outputs.
    // The memory address for column 0 of the next line is set up at the
    // latch edge (or held at 0 in IDLE), so every column sees its address
    // stable for two cycles before capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sh_ph       <= SH_CAP;
            sh_busy     <= 1'b0;
            sh_col      <= '0;
            shift_row   <= '0;
            shift_plane <= 3'd2;
            timer       <= '0;
            addr_q      <= '0;
            plane_q     <= 3'd2;
            data_q      <= '0;
            hclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            row_q       <= '0;
            fs_q        <= 1'b0;
        end else if (!enable) begin
            state       <= IDLE;
            sh_ph       <= SH_CAP;
            sh_busy     <= 1'b0;
            sh_col      <= '0;
            shift_row   <= '0;
            shift_plane <= 3'd2;
            timer       <= '0;
            addr_q      <= '0;
            plane_q     <= 3'd2;
            data_q      <= '0;
            hclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            row_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            if (sh_busy) begin
                case (sh_ph)
                    SH_CAP: begin
                        data_q <= {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1};
                        hclk_q <= 1'b0;
                        sh_ph  <= SH_HIGH;
                        if (sh_col != LAST_COL) begin
                            addr_q <= {shift_row, sh_col + COL_BITS'(1)};
                        end
                    end
                    SH_HIGH: begin
                        hclk_q <= 1'b1;
                        if (sh_col == LAST_COL) begin
                            sh_ph <= SH_END;
                        end else begin
                            sh_col <= sh_col + COL_BITS'(1);
                            sh_ph  <= SH_CAP;
                        end
                    end
                    default: begin
                        hclk_q  <= 1'b0;
                        sh_busy <= 1'b0;
                    end
                endcase
            end

            case (state)
                IDLE: begin
                    oe_n_q  <= 1'b1;
                    state   <= PRIME;
                    sh_busy <= 1'b1;
                    sh_ph   <= SH_CAP;
                    sh_col  <= '0;
                end
                PRIME: begin
                    if (sh_last) begin
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    state       <= LATCH;
                    lat_q       <= 1'b1;
                    row_q       <= shift_row;
                    timer       <= BASE << (shift_plane - 3'd2);
                    fs_q        <= (shift_row == 5'd0) && (shift_plane == 3'd2);
                    shift_row   <= nxt_row;
                    shift_plane <= nxt_plane;
                    addr_q      <= {nxt_row, {COL_BITS{1'b0}}};
                    plane_q     <= nxt_plane;
                end
                LATCH: begin
                    state   <= RUN;
                    lat_q   <= 1'b0;
                    fs_q    <= 1'b0;
                    oe_n_q  <= 1'b0;
                    sh_busy <= 1'b1;
                    sh_ph   <= SH_CAP;
                    sh_col  <= '0;
                end
                RUN: begin
                    if (!oe_n_q) begin
                        timer <= timer - BCM_CNT_W'(1);
                        if (timer == BCM_CNT_W'(1)) begin
                            oe_n_q <= 1'b1;
                        end
                    end
                    if (sh_free && (timer == '0)) begin
                        state <= BLANK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
